// File: rtl/button_pulse_gen.sv
// Push-button conditioner for the PWM duty counter: synchronise, debounce,
// detect presses, auto-repeat while held, and arbitrate opposing inc/dec pairs.
module button_pulse_gen #(
  parameter int N_BTN        = 4,
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16,
  parameter int CW           = 16
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pulse,
  output logic [N_BTN-1:0] level
);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] w_rival;
  logic [N_BTN-1:0] r_pulse;

  genvar g;
  generate
    for (g = 0; g < N_BTN; g++) begin : g_btn
      logic          r_sync_p0;
      logic          r_sync_p1;
      logic          r_level;
      logic [CW-1:0] r_db_cnt;
      logic [CW-1:0] r_rt;
      state_t        r_state;

      always_ff @(posedge clkin) begin
        if (reset) begin
          r_sync_p0 <= 1'b0;
          r_sync_p1 <= 1'b0;
          r_level   <= 1'b0;
          r_db_cnt  <= '0;
          r_rt      <= '0;
          r_state   <= IDLE;
        end else begin
          r_sync_p0 <= ~btn_n[g];
          r_sync_p1 <= r_sync_p0;

          // Level only moves after DB_CYCLES consecutive disagreeing samples.
          if (r_sync_p1 == r_level) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_LAST) begin
            r_level  <= r_sync_p1;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + CW'(1);
          end

          case (r_state)
            IDLE: begin
              if (r_level) begin
                r_state <= FIRST;
                r_rt    <= '0;
              end
            end
            FIRST: begin
              if (!r_level) begin
                r_state <= IDLE;
              end else if (REPEAT_EN != 0) begin
                if (r_rt == DLY_LAST) begin
                  r_state <= REPEAT;
                  r_rt    <= '0;
                end else begin
                  r_rt <= r_rt + CW'(1);
                end
              end
            end
            REPEAT: begin
              if (!r_level) begin
                r_state <= IDLE;
              end else if (r_rt == RATE_LAST) begin
                r_rt <= '0;
              end else begin
                r_rt <= r_rt + CW'(1);
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end

      assign w_raw[g] = r_level &&
                        ((r_state == IDLE) ||
                         ((r_state == FIRST) && (REPEAT_EN != 0) && (r_rt == DLY_LAST)) ||
                         ((r_state == REPEAT) && (r_rt == RATE_LAST)));
      assign level[g] = r_level;

      // inc/dec partners are bit pairs (0,2) and (1,3).
      if ((g < 4) && ((g ^ 2) < N_BTN)) begin : g_pair
        assign w_rival[g] = w_raw[g ^ 2];
      end else begin : g_solo
        assign w_rival[g] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_raw & ~w_rival;
    end
  end

  assign pulse = r_pulse;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: directed scenarios with absolute timing plus
// randomized presses checked every cycle against a timing-rule reference model.
module tb_button_pulse_gen;
  localparam int DB   = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_n, btn_n2;
  logic [3:0] pulse, level, pulse2, level2;

  always #5 clk = ~clk;

  button_pulse_gen #(.N_BTN(4), .DB_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(DLY),
                     .REPEAT_RATE(RATE), .CW(16)) dut (
    .clkin(clk), .reset(reset), .btn_n(btn_n), .pulse(pulse), .level(level));

  button_pulse_gen #(.N_BTN(4), .DB_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(DLY),
                     .REPEAT_RATE(RATE), .CW(16)) dut_nr (
    .clkin(clk), .reset(reset), .btn_n(btn_n2), .pulse(pulse2), .level(level2));

  int errors = 0;
  int checks = 0;

  // Reference model: synchroniser delay, run-length debounce, and pulse times
  // computed from the age of the press (first pulse, +DELAY, then every RATE).
  bit         mq1 [2][4];
  bit         mq2 [2][4];
  bit         mlvl[2][4];
  int         mrun[2][4];
  int         mrise[2][4];
  int         medge = 0;
  logic [3:0] mp[2];
  logic [3:0] ml[2];

  task automatic model_step(input int u, input logic rst, input logic [3:0] bn, input bit rep);
    logic [3:0] raw;
    raw = '0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mq1[u][i] = 0; mq2[u][i] = 0; mlvl[u][i] = 0; mrun[u][i] = 0;
      end
      mp[u] = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mlvl[u][i]) begin
          int age;
          age = medge - mrise[u][i] - 1;
          if (age == 0 || (rep && age >= DLY && ((age - DLY) % RATE) == 0)) raw[i] = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (mq2[u][i] != mlvl[u][i]) begin
          mrun[u][i]++;
          if (mrun[u][i] == DB) begin
            mlvl[u][i] = mq2[u][i];
            mrun[u][i] = 0;
            if (mlvl[u][i]) mrise[u][i] = medge;
          end
        end else begin
          mrun[u][i] = 0;
        end
        mq2[u][i] = mq1[u][i];
        mq1[u][i] = ~bn[i];
      end
      for (int i = 0; i < 4; i++) mp[u][i] = raw[i] & ~raw[i ^ 2];
    end
    for (int i = 0; i < 4; i++) ml[u][i] = mlvl[u][i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, reset, btn_n, 1'b1);
    model_step(1, reset, btn_n2, 1'b0);
    medge++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    btn_n = 4'hF; btn_n2 = 4'hF; reset = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_n = 4'hF; btn_n2 = 4'hF;
    tick(); tick();
    checks++;
    if (pulse !== 4'h0 || level !== 4'h0 || pulse2 !== 4'h0 || level2 !== 4'h0) begin
      errors++;
      $display("FAIL reset: pulse=%b level=%b pulse2=%b level2=%b, required all 0",
               pulse, level, pulse2, level2);
    end
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      checks++;
      if (pulse !== 4'h0 || level !== 4'h0) begin
        errors++;
        $display("FAIL reset_idle: pulse=%b level=%b, required 0000 0000", pulse, level);
      end
    end
  endtask

  task automatic test_single_press();
    int first_lvl, npulse, pulse_at;
    first_lvl = -1; npulse = 0; pulse_at = -1;
    for (int j = 0; j < 40; j++) begin
      btn_n = (j < 10) ? 4'b1110 : 4'b1111;
      tick();
      checks++;
      if (pulse !== mp[0] || level !== ml[0]) begin
        errors++;
        $display("FAIL single_model j=%0d: pulse=%b level=%b, required %b %b", j, pulse, level, mp[0], ml[0]);
      end
      if (level[0] && first_lvl < 0) first_lvl = j;
      if (pulse[0]) begin npulse++; pulse_at = j; end
    end
    checks++;
    if (first_lvl != 5) begin
      errors++; $display("FAIL single_level_edge: got %0d, required 5", first_lvl);
    end
    checks++;
    if (npulse != 1 || pulse_at != 6) begin
      errors++; $display("FAIL single_pulse: count=%0d at=%0d, required 1 at 6", npulse, pulse_at);
    end
    idle(10);
  endtask

  task automatic test_glitch();
    bit seen;
    seen = 0;
    for (int j = 0; j < 30; j++) begin
      btn_n = (j < 3) ? 4'b1101 : 4'b1111;
      tick();
      checks++;
      if (pulse !== mp[0] || level !== ml[0]) begin
        errors++;
        $display("FAIL glitch_model j=%0d: pulse=%b level=%b, required %b %b", j, pulse, level, mp[0], ml[0]);
      end
      if (level[1] || pulse[1]) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL glitch: level/pulse[1] went high, required to stay 0");
    end
    idle(10);
  endtask

  task automatic test_repeat();
    int got[$];
    int exp_t[6] = '{6, 26, 34, 42, 50, 58};
    for (int j = 0; j < 80; j++) begin
      btn_n = (j < 60) ? 4'b1011 : 4'b1111;
      tick();
      checks++;
      if (pulse !== mp[0] || level !== ml[0]) begin
        errors++;
        $display("FAIL repeat_model j=%0d: pulse=%b level=%b, required %b %b", j, pulse, level, mp[0], ml[0]);
      end
      if (pulse[2]) got.push_back(j);
    end
    checks++;
    if (got.size() != 6) begin
      errors++; $display("FAIL repeat_count: got %0d pulses, required 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[k] != exp_t[k]) begin
          errors++; $display("FAIL repeat_time[%0d]: got %0d, required %0d", k, got[k], exp_t[k]);
        end
      end
    end
    idle(10);
  endtask

  task automatic test_conflict();
    bit bad, lv0, lv2;
    bad = 0; lv0 = 0; lv2 = 0;
    for (int j = 0; j < 30; j++) begin
      btn_n = (j < 10) ? 4'b1010 : 4'b1111;
      tick();
      checks++;
      if (pulse !== mp[0] || level !== ml[0]) begin
        errors++;
        $display("FAIL conflict_model j=%0d: pulse=%b level=%b, required %b %b", j, pulse, level, mp[0], ml[0]);
      end
      if (pulse[0] || pulse[2]) bad = 1;
      if (level[0]) lv0 = 1;
      if (level[2]) lv2 = 1;
    end
    checks++;
    if (bad || !lv0 || !lv2) begin
      errors++;
      $display("FAIL conflict: pulse_seen=%0d level0=%0d level2=%0d, required 0 1 1", bad, lv0, lv2);
    end
    idle(10);
  endtask

  task automatic test_reset_midpress();
    int got[$];
    for (int j = 0; j < 40; j++) begin
      btn_n = 4'b0111;
      reset = (j == 15);
      tick();
      checks++;
      if (pulse !== mp[0] || level !== ml[0]) begin
        errors++;
        $display("FAIL midreset_model j=%0d: pulse=%b level=%b, required %b %b", j, pulse, level, mp[0], ml[0]);
      end
      if (j == 15) begin
        checks++;
        if (pulse !== 4'h0 || level !== 4'h0) begin
          errors++; $display("FAIL midreset_clear: pulse=%b level=%b, required 0000 0000", pulse, level);
        end
      end
      if (pulse[3]) got.push_back(j);
    end
    checks++;
    if (got.size() != 2 || got[0] != 6 || got[1] != 22) begin
      errors++;
      $display("FAIL midreset_pulses: count=%0d first=%0d last=%0d, required 2 at 6,22",
               got.size(), (got.size() > 0) ? got[0] : -1, (got.size() > 0) ? got[got.size()-1] : -1);
    end
    reset = 1'b0;
    idle(30);
  endtask

  task automatic test_no_repeat();
    int npulse, pulse_at;
    npulse = 0; pulse_at = -1;
    for (int j = 0; j < 120; j++) begin
      btn_n2 = (j < 100) ? 4'b1101 : 4'b1111;
      tick();
      checks++;
      if (pulse2 !== mp[1] || level2 !== ml[1]) begin
        errors++;
        $display("FAIL norepeat_model j=%0d: pulse=%b level=%b, required %b %b", j, pulse2, level2, mp[1], ml[1]);
      end
      if (pulse2[1]) begin npulse++; pulse_at = j; end
    end
    checks++;
    if (npulse != 1 || pulse_at != 6) begin
      errors++; $display("FAIL norepeat_pulse: count=%0d at=%0d, required 1 at 6", npulse, pulse_at);
    end
    idle(10);
  endtask

  task automatic test_random();
    logic [3:0] prev, prev2;
    prev = '0; prev2 = '0;
    for (int j = 0; j < 3000; j++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 11) == 0) btn_n[b]  = ~btn_n[b];
        if ($urandom_range(0, 11) == 0) btn_n2[b] = ~btn_n2[b];
      end
      reset = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (pulse !== mp[0] || level !== ml[0] || pulse2 !== mp[1] || level2 !== ml[1]) begin
        errors++;
        $display("FAIL random_model j=%0d: %b %b %b %b, required %b %b %b %b",
                 j, pulse, level, pulse2, level2, mp[0], ml[0], mp[1], ml[1]);
      end
      checks++;
      if (((pulse & prev) | (pulse2 & prev2)) !== 4'h0) begin
        errors++;
        $display("FAIL random_back_to_back j=%0d: pulse=%b prev=%b, required no repeat", j, pulse, prev);
      end
      prev = pulse; prev2 = pulse2;
    end
    reset = 1'b0;
    idle(10);
  endtask

  initial begin
    reset = 1'b1; btn_n = 4'hF; btn_n2 = 4'hF;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_conflict();
    test_reset_midpress();
    test_no_repeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
